// File: rtl/stream_fifo.sv
// Synchronous valid/ready stream FIFO with first-word fall-through, occupancy count and sticky overflow.
// Latency: a word pushed into an empty FIFO appears on out_data one cycle after the push edge.
// Backpressure: in_ready drops only when full and the consumer is not popping this cycle.
//
// Ports:
//   clk, reset_n        - single clock, asynchronous active-low reset
//   in_valid/in_ready   - write handshake, in_data is the write word
//   out_valid/out_ready - read handshake, out_data is the oldest stored word
//   count               - registered occupancy (0..DEPTH)
//   almost_full         - count >= AF_LEVEL
//   overflow            - sticky: set by a write attempt while in_ready is low
//   clear               - synchronous flush, overrides every other event
module stream_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clear
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full;
  logic             push;
  logic             pop;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count_q == FULL_CNT);
  assign out_valid   = (count_q != '0);
  // When full, a simultaneous pop frees the slot the push will use.
  assign in_ready    = !full || out_ready;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= AF_CNT);
  assign overflow    = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // The rejected word is simply dropped; only the flag records it.
      if (in_valid && !in_ready) begin
        overflow_d = 1'b1;
      end
    end
  end

  // reset_n is expected to be released synchronously to clk by the reset
  // distribution upstream, so the first high edge can already accept a push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=8, DEPTH=4, AF_LEVEL=3
  logic       rst_a;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af, a_ovf, a_clear;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_count;

  // DUT B: WIDTH=8, DEPTH=5, AF_LEVEL=4
  logic       rst_b;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af, b_ovf, b_clear;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_count;

  stream_fifo #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .reset_n(rst_a),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .almost_full(a_af), .overflow(a_ovf), .clear(a_clear)
  );

  stream_fifo #(.WIDTH(8), .DEPTH(5)) u_b (
    .clk(clk), .reset_n(rst_b),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .almost_full(b_af), .overflow(b_ovf), .clear(b_clear)
  );

  int         total = 0;
  int         bad   = 0;

  // Scoreboard for DUT A and values captured just before each edge.
  logic [7:0] sb_a[$];
  bit         m_ovf_a;
  logic       obs_rdy, obs_vld;
  logic [7:0] obs_dat;
  bit         exp_rdy, exp_pop;
  logic [7:0] exp_dat;

  // Drives one cycle on DUT A and advances the reference queue.
  task automatic a_drive(input bit vld, input logic [7:0] d, input bit ordy, input bit clr);
    a_in_valid  = vld;
    a_in_data   = d;
    a_out_ready = ordy;
    a_clear     = clr;
    #1;
    obs_rdy = a_in_ready;
    obs_vld = a_out_valid;
    obs_dat = a_out_data;
    exp_rdy = (sb_a.size() < 4) || ordy;
    exp_pop = (sb_a.size() != 0) && ordy && !clr;
    exp_dat = exp_pop ? sb_a[0] : 8'h00;
    @(posedge clk);
    #1;
    if (clr) begin
      sb_a.delete();
      m_ovf_a = 1'b0;
    end else begin
      if (exp_pop) void'(sb_a.pop_front());
      if (vld && exp_rdy) sb_a.push_back(d);
      if (vld && !exp_rdy) m_ovf_a = 1'b1;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0; a_clear = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_clear = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    total++; if (a_af !== 1'b0) begin bad++; $display("FAIL reset_almost_full: got %b want 0", a_af); end
    total++; if (a_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", a_count); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", a_ovf); end
    total++; if (b_count !== 3'd0) begin bad++; $display("FAIL reset_b_count: got %0d want 0", b_count); end
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk);
    #1;
    sb_a.delete();
    m_ovf_a = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b1, 8'((i + 1) * 17), 1'b0, 1'b0);
      total++; if (obs_rdy !== 1'b1) begin bad++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, obs_rdy); end
      total++; if (a_count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, a_count, i + 1); end
      total++; if (a_af !== (i >= 2)) begin bad++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, a_af, (i >= 2)); end
    end
    a_out_ready = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", a_in_ready); end
    total++; if (a_out_data !== 8'h11) begin bad++; $display("FAIL full_head: got %0h want 11", a_out_data); end
  endtask

  task automatic test_overflow();
    a_drive(1'b1, 8'h55, 1'b0, 1'b0);
    total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL ovf_in_ready: got %b want 0", obs_rdy); end
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", a_ovf); end
    total++; if (a_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", a_count); end
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL ovf_drain[%0d]: got %0h want %0h", i, obs_dat, exp_dat); end
      total++; if (obs_dat !== 8'((i + 1) * 17)) begin bad++; $display("FAIL ovf_order[%0d]: got %0h want %0h", i, obs_dat, 8'((i + 1) * 17)); end
    end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", a_out_valid); end
    total++; if (a_ovf !== m_ovf_a) begin bad++; $display("FAIL ovf_sticky: got %b want %b", a_ovf, m_ovf_a); end
    a_drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared: got %b want 0", a_ovf); end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) a_drive(1'b1, 8'((i + 1) * 17), 1'b0, 1'b0);
    a_drive(1'b1, 8'h55, 1'b1, 1'b0);
    total++; if (obs_rdy !== 1'b1) begin bad++; $display("FAIL pp_in_ready: got %b want 1", obs_rdy); end
    total++; if (obs_dat !== 8'h11) begin bad++; $display("FAIL pp_popped: got %0h want 11", obs_dat); end
    total++; if (a_count !== 3'd4) begin bad++; $display("FAIL pp_count: got %0d want 4", a_count); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL pp_overflow: got %b want 0", a_ovf); end
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL pp_drain[%0d]: got %0h want %0h", i, obs_dat, exp_dat); end
    end
    total++; if (a_count !== 3'd0) begin bad++; $display("FAIL pp_final_count: got %0d want 0", a_count); end
  endtask

  task automatic test_empty();
    a_drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (a_count !== 3'd0) begin bad++; $display("FAIL empty_pop_count: got %0d want 0", a_count); end
    a_drive(1'b1, 8'h3C, 1'b1, 1'b0);
    total++; if (obs_vld !== 1'b0) begin bad++; $display("FAIL empty_pre_valid: got %b want 0", obs_vld); end
    total++; if (a_count !== 3'd1) begin bad++; $display("FAIL empty_push_count: got %0d want 1", a_count); end
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h3C) begin bad++; $display("FAIL empty_fwft: got %b/%0h want 1/3c", a_out_valid, a_out_data); end
    a_drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL empty_drain: got %0h want %0h", obs_dat, exp_dat); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) a_drive(1'b1, 8'(i), 1'b0, 1'b0);
    total++; if (a_count !== 3'd3) begin bad++; $display("FAIL rst_pre_count: got %0d want 3", a_count); end
    rst_a = 1'b0;
    #2;
    total++; if (a_count !== 3'd0) begin bad++; $display("FAIL rst_async_count: got %0d want 0", a_count); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b want 0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready: got %b want 1", a_in_ready); end
    sb_a.delete();
    m_ovf_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    a_drive(1'b1, 8'hA5, 1'b0, 1'b0);
    a_drive(1'b1, 8'hB6, 1'b0, 1'b0);
    total++; if (a_count !== 3'd2) begin bad++; $display("FAIL rst_post_count: got %0d want 2", a_count); end
    a_drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (obs_dat !== 8'hA5) begin bad++; $display("FAIL rst_first_word: got %0h want a5", obs_dat); end
    a_drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (obs_dat !== exp_dat) begin bad++; $display("FAIL rst_second_word: got %0h want %0h", obs_dat, exp_dat); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) a_drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    a_drive(1'b1, 8'h55, 1'b0, 1'b0);
    a_drive(1'b0, 8'h00, 1'b1, 1'b0);
    a_drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (a_count !== 3'd2 || a_ovf !== 1'b1) begin bad++; $display("FAIL clr_setup: got count=%0d ovf=%b want 2/1", a_count, a_ovf); end
    a_drive(1'b1, 8'h77, 1'b0, 1'b1);
    total++; if (a_count !== 3'd0) begin bad++; $display("FAIL clr_count: got %0d want 0", a_count); end
    total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL clr_overflow: got %b want 0", a_ovf); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL clr_out_valid: got %b want 0", a_out_valid); end
    a_drive(1'b1, 8'h99, 1'b0, 1'b0);
    a_drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (obs_dat !== exp_dat || obs_dat !== 8'h99) begin bad++; $display("FAIL clr_after: got %0h want 99", obs_dat); end
  endtask

  task automatic test_stream_b();
    logic [7:0] sb_b[$];
    int         sent = 0;
    int         got  = 0;
    bit         e_rdy, e_pop;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      b_in_valid  = (sent < 20);
      b_in_data   = sent[7:0];
      b_out_ready = 1'($urandom_range(0, 1));
      #1;
      e_rdy = (sb_b.size() < 5) || b_out_ready;
      e_pop = (sb_b.size() != 0) && b_out_ready;
      total++; if (b_in_ready !== e_rdy) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b want %b", cyc, b_in_ready, e_rdy); end
      if (e_pop) begin
        total++; if (b_out_data !== sb_b[0] || b_out_data !== got[7:0]) begin bad++; $display("FAIL stream_data[%0d]: got %0h want %0h", got, b_out_data, got[7:0]); end
        void'(sb_b.pop_front());
        got++;
      end
      if (b_in_valid && e_rdy) begin
        sb_b.push_back(b_in_data);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    total++; if (got != 20) begin bad++; $display("FAIL stream_timeout: got %0d words want 20", got); end
    total++; if (b_count !== 3'd0) begin bad++; $display("FAIL stream_final_count: got %0d want 0", b_count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_pushpop();
    test_empty();
    test_reset_mid();
    test_clear();
    test_stream_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 4: number of storage entries, legal range 2 or more, any integer value (not restricted to a power of two).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: occupancy at or above which almost_full is asserted, legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: FIFO accepts a word this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: write data.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds the oldest stored word.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-011 SHALL have port out_data, output, WIDTH bits: oldest stored word.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-013 SHALL have port almost_full, output, 1 bit: count >= AF_LEVEL.
REQ-014 SHALL have port overflow, output, 1 bit: sticky error flag.
REQ-015 SHALL have port clear, input, 1 bit: synchronous flush.

Function
REQ-016 Push SHALL occur on the rising edge when in_valid && in_ready; pop SHALL occur on the rising edge when out_valid && out_ready.
REQ-017 in_ready SHALL be asserted when count < DEPTH, or when count == DEPTH && out_ready, so that push and pop are accepted in the same cycle while full.
REQ-018 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry with first-word fall-through, so a word pushed into an empty FIFO is visible on the cycle after the push edge.
REQ-019 out_data SHALL be held stable while out_valid && !out_ready.
REQ-020 count SHALL update each edge as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or on neither.
REQ-021 The write and read pointers SHALL each wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-022 Data SHALL leave in exact push order, with no loss or duplication, across wrap-around.
REQ-023 Push and pop in the same cycle while empty SHALL be impossible, because out_valid is 0; the push is accepted and count becomes 1.
REQ-024 A write attempt (in_valid && !in_ready) SHALL set overflow to 1; overflow SHALL clear only by reset or clear; the attempted word SHALL be dropped and storage left unchanged.
REQ-025 A pop attempt while empty SHALL have no effect.
REQ-026 clear SHALL, on the rising edge, zero both pointers, count and overflow; pushes and pops in that cycle SHALL be ignored; clear SHALL take priority over every other event.
REQ-027 almost_full SHALL be derived combinationally from the registered count.

Reset
REQ-028 While reset_n == 0, the block SHALL asynchronously force both pointers, count and overflow to 0, giving out_valid=0, in_ready=1, almost_full=0, count=0, overflow=0.
REQ-029 Storage contents SHALL NOT require reset; out_data is don't-care while out_valid == 0.
REQ-030 A reset asserted mid-operation SHALL discard all stored words; the first push after reset_n rises SHALL be the first word popped.
REQ-031 Deassertion of reset_n SHALL be synchronous to clk; the first push SHALL be accepted on the first rising edge at which reset_n is high.

Verification
REQ-032 Test SHALL cover: WIDTH=8, DEPTH=4, out_ready=0, push 0x11,0x22,0x33,0x44 -> count 1..4; almost_full=1 at count 3; in_ready=0 at count 4.
REQ-033 Test SHALL cover: FIFO full, in_valid=1 with 0x55 and out_ready=0 -> overflow=1, count stays 4; then drain -> 0x11,0x22,0x33,0x44 only.
REQ-034 Test SHALL cover: FIFO full, in_valid=1 with 0x55 and out_ready=1 in the same cycle -> 0x11 popped, 0x55 stored, count stays 4, overflow stays 0.
REQ-035 Test SHALL cover: DEPTH=5, streaming 20 words with in_valid=1 and random out_ready -> output sequence equals input sequence across 4 wrap-arounds.
REQ-036 Test SHALL cover: FIFO holding 3 words, reset_n pulled low between clock edges -> count=0 and out_valid=0 immediately; push 0xA5 after release -> 0xA5 popped first.
REQ-037 Test SHALL cover: overflow=1 with count=2, clear=1 for one cycle together with a push -> count=0, overflow=0, out_valid=0.
